// File: rtl/aes_key_sched_ctrl.sv
// Key-schedule sequencer: drives a single-round AES-128 expansion unit and keeps all round keys.
// Optional expansion-timeout watchdog: define KEY_SCHED_TIMEOUT_EN.
module aes_key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS  = 10,
    parameter int unsigned KEY_W       = 128,
    parameter int unsigned EXP_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [KEY_W-1:0] cipher_key,
    output logic             busy,
    output logic             keys_valid,
    output logic             exp_enable,
    output logic [3:0]       exp_round,
    output logic [KEY_W-1:0] exp_past_key,
    input  logic [KEY_W-1:0] exp_new_key,
    input  logic             exp_done,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic             err
);
    localparam int unsigned RND_W    = 4;
    localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
        $error("NUM_ROUNDS must be in 1..15");
    end
    if (EXP_TIMEOUT < 1) begin : g_bad_timeout
        $error("EXP_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state;
    logic [RND_W-1:0] round;
    logic [KEY_W-1:0] rk [NUM_KEYS];
    logic             timeout_c;

    // Sequencer: every output is registered alongside the state transition.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            round        <= '0;
            busy         <= 1'b0;
            keys_valid   <= 1'b0;
            exp_enable   <= 1'b0;
            exp_round    <= '0;
            exp_past_key <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                rk[i] <= '0;
            end
        end else begin
            exp_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rk[0]        <= cipher_key;
                        round        <= RND_W'(1);
                        keys_valid   <= 1'b0;
                        busy         <= 1'b1;
                        exp_enable   <= 1'b1;
                        exp_round    <= RND_W'(1);
                        exp_past_key <= cipher_key;
                        state        <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    // A result landing on the expiry cycle still wins over the timeout.
                    if (exp_done) begin
                        rk[round] <= exp_new_key;
                        if (round == LAST_ROUND) begin
                            state <= DONE;
                        end else begin
                            round        <= round + RND_W'(1);
                            exp_round    <= round + RND_W'(1);
                            exp_past_key <= exp_new_key;
                            exp_enable   <= 1'b1;
                            state        <= REQ;
                        end
                    end else if (timeout_c) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    keys_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_SCHED_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(EXP_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(EXP_TIMEOUT - 1);

    logic [WCNT_W-1:0] wait_cnt;

    assign timeout_c = (state == WAIT) && (wait_cnt == WCNT_LAST);

    // Watchdog: counts WAIT cycles of the current round, raises a sticky err on expiry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (state == REQ) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !timeout_c) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end
            if (state == IDLE && start) begin
                err <= 1'b0;
            end else if (timeout_c && !exp_done) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    // Combinational read port; indices past the last round read as zero.
    always_comb begin
        rd_key = '0;
        if (32'(rd_round) < NUM_KEYS) begin
            rd_key = rk[rd_round];
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 expansion unit, key-schedule model, directed runs.
module tb_aes_key_sched_ctrl;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned NR    = 10;

    localparam logic [KEY_W-1:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [KEY_W-1:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [KEY_W-1:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [KEY_W-1:0] K6     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [KEY_W-1:0] K6_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic             start = 1'b0;
    logic [KEY_W-1:0] cipher_key = '0;
    logic             busy, keys_valid, exp_enable, err;
    logic [3:0]       exp_round;
    logic [KEY_W-1:0] exp_past_key;
    logic [KEY_W-1:0] exp_new_key = '0;
    logic             exp_done = 1'b0;
    logic [3:0]       rd_round = '0;
    logic [KEY_W-1:0] rd_key;

    int n_checks = 0;
    int n_fail   = 0;

    // Expansion-unit controls and model state shared between processes.
    int               unit_delay [16];
    logic [3:0]       unit_hold_round = '0;
    int               inject_req = 0;
    int               inject_ack = 0;
    logic [KEY_W-1:0] mdl_rk [16];
    int               pulses = 0;
    logic             prev_en = 1'b0;
    logic             prev_kv = 1'b0;
    logic             chk_accept = 1'b0;
    logic [3:0]       held_round = '0;
    logic [KEY_W-1:0] held_past = '0;

    aes_key_sched_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .cipher_key   (cipher_key),
        .busy         (busy),
        .keys_valid   (keys_valid),
        .exp_enable   (exp_enable),
        .exp_round    (exp_round),
        .exp_past_key (exp_past_key),
        .exp_new_key  (exp_new_key),
        .exp_done     (exp_done),
        .rd_round     (rd_round),
        .rd_key       (rd_key),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [KEY_W-1:0] expand_round(input logic [KEY_W-1:0] prev, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = prev[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = xtime(rc);
        t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])} ^ {rc, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Behavioural expansion unit: answers each request after unit_delay[round] extra cycles.
    initial begin
        int               cnt;
        logic             pend;
        logic [KEY_W-1:0] nk;
        cnt  = 0;
        pend = 1'b0;
        nk   = '0;
        forever begin
            @(negedge clk);
            exp_done    = 1'b0;
            exp_new_key = '0;
            if (!n_rst) begin
                pend = 1'b0;
                continue;
            end
            if (inject_req != inject_ack) begin
                exp_done    = 1'b1;
                exp_new_key = {4{32'hdeadbeef}};
                inject_ack  = inject_req;
            end else if (pend) begin
                if (cnt == 0) begin
                    exp_done    = 1'b1;
                    exp_new_key = nk;
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (exp_enable && exp_round != unit_hold_round) begin
                pend = 1'b1;
                cnt  = unit_delay[exp_round];
                nk   = expand_round(exp_past_key, int'(exp_round));
            end
        end
    end

    // Per-cycle checker against the key-schedule model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!n_rst) begin
                pulses     = 0;
                prev_en    = 1'b0;
                prev_kv    = 1'b0;
                chk_accept = 1'b0;
                continue;
            end
            if (chk_accept) begin
                check("accept_busy", 128'(busy), 128'(1'b1));
                check("accept_kv", 128'(keys_valid), 128'(1'b0));
                chk_accept = 1'b0;
            end
            check("kv_while_busy", 128'(busy & keys_valid), 128'(1'b0));
`ifndef KEY_SCHED_TIMEOUT_EN
            check("err_tied", 128'(err), 128'(1'b0));
`endif
            if (exp_enable) begin
                check("en_one_cycle", 128'(prev_en), 128'(1'b0));
                pulses++;
                check("en_round", 128'(exp_round), 128'(pulses));
                if (pulses <= int'(NR)) check("en_past_key", exp_past_key, mdl_rk[pulses-1]);
                held_round = exp_round;
                held_past  = exp_past_key;
            end else if (busy && pulses > 0) begin
                check("hold_round", 128'(held_round), 128'(exp_round));
                check("hold_past_key", exp_past_key, held_past);
            end
            if (keys_valid && !prev_kv) check("pulses_at_valid", 128'(pulses), 128'(NR));
            if (keys_valid) check("rd_key", rd_key, mdl_rk[rd_round]);
            if (start && !busy) begin
                mdl_rk[0] = cipher_key;
                for (int r = 1; r < 16; r++) begin
                    mdl_rk[r] = (r <= int'(NR)) ? expand_round(mdl_rk[r-1], r) : '0;
                end
                pulses     = 0;
                chk_accept = 1'b1;
            end
            prev_en = exp_enable;
            prev_kv = keys_valid;
        end
    end

    task automatic launch(input logic [KEY_W-1:0] key);
        @(negedge clk);
        start      = 1'b1;
        cipher_key = key;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Edges counted with the start-sampling edge as edge 1.
    task automatic wait_valid(input string name, input int exp_edges);
        int edges;
        edges = 1;
        while (!keys_valid && edges < 400) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_latency"}, 128'(edges), 128'(exp_edges));
        check({name, "_pulses"}, 128'(pulses), 128'(NR));
    endtask

    task automatic read_check(input string name, input logic [3:0] idx, input logic [KEY_W-1:0] exp);
        @(negedge clk);
        rd_round = idx;
        #1;
        check(name, rd_key, exp);
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < 16; i++) unit_delay[i] = d;
    endtask

    initial begin
        int exp_lat;
        int edges;
        int n;
        int wcnt;
        logic injected;
        int t2_delay [10];
        t2_delay = '{3, 0, 5, 1, 2, 4, 0, 5, 2, 1};
        for (int i = 0; i < 16; i++) mdl_rk[i] = '0;
        set_delays(0);

        #3 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_kv", 128'(keys_valid), 128'(1'b0));
        check("rst_en", 128'(exp_enable), 128'(1'b0));
        check("rst_err", 128'(err), 128'(1'b0));
        check("rst_round", 128'(exp_round), 128'(4'd0));
        check("rst_rd0", rd_key, '0);
        @(negedge clk);
        n_rst = 1'b1;

        // T1: FIPS-197 key, zero-wait unit.
        launch(K1);
        wait_valid("t1", 22);
        read_check("t1_rk0", 4'd0, K1);
        read_check("t1_rk1", 4'd1, K1_R1);
        read_check("t1_rk10", 4'd10, K1_R10);
        read_check("t1_rk11", 4'd11, '0);
        read_check("t1_rk15", 4'd15, '0);

        // T2: per-round response delays 0..5.
        exp_lat = 2;
        for (int r = 1; r <= int'(NR); r++) begin
            unit_delay[r] = t2_delay[r-1];
            exp_lat += 2 + t2_delay[r-1];
        end
        check("t2_formula", 128'(exp_lat), 128'(45));
        launch(K1);
        wait_valid("t2", exp_lat);
        read_check("t2_rk10", 4'd10, K1_R10);

        // T3: start during WAIT and exp_done during IDLE are both ignored.
        set_delays(2);
        launch(K1);
        edges    = 1;
        injected = 1'b0;
        while (!keys_valid && edges < 400) begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (!injected && edges > 6 && busy && !exp_enable) begin
                start      = 1'b1;
                cipher_key = K6;
                injected   = 1'b1;
            end
        end
        start = 1'b0;
        check("t3_latency", 128'(edges), 128'(42));
        repeat (2) @(negedge clk);
        inject_req++;
        repeat (3) @(negedge clk);
        check("t3_idle_busy", 128'(busy), 128'(1'b0));
        check("t3_idle_kv", 128'(keys_valid), 128'(1'b1));
        read_check("t3_rk10", 4'd10, K1_R10);
        read_check("t3_rk1", 4'd1, K1_R1);
        read_check("t3_rk0", 4'd0, K1);

        // T4: reset during round-5 WAIT, then a clean run.
        set_delays(3);
        launch(K1);
        n = 0;
        while (!(exp_round == 4'd5 && busy && !exp_enable) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_r5", 128'(n < 400), 128'(1'b1));
        n_rst = 1'b0;
        #1;
        check("t4_busy", 128'(busy), 128'(1'b0));
        check("t4_kv", 128'(keys_valid), 128'(1'b0));
        check("t4_en", 128'(exp_enable), 128'(1'b0));
        for (int i = 0; i < 16; i++) begin
            rd_round = 4'(i);
            #1;
            check("t4_rd_zero", rd_key, '0);
        end
        @(negedge clk);
        n_rst = 1'b1;
        set_delays(0);
        launch(K1);
        wait_valid("t4", 22);
        read_check("t4_rk10", 4'd10, K1_R10);

        // T5: expansion unit never answers round 3.
        unit_hold_round = 4'd3;
        launch(K1);
`ifdef KEY_SCHED_TIMEOUT_EN
        n    = 1;
        wcnt = 0;
        while (busy && n < 400) begin
            if (exp_round == 4'd3 && !exp_enable) wcnt++;
            @(negedge clk);
            n++;
        end
        check("t5_wait_cycles", 128'(wcnt), 128'(32));
        check("t5_err", 128'(err), 128'(1'b1));
        check("t5_busy", 128'(busy), 128'(1'b0));
        check("t5_kv", 128'(keys_valid), 128'(1'b0));
        unit_hold_round = 4'd0;
        launch(K1);
        check("t5_err_clear", 128'(err), 128'(1'b0));
        wait_valid("t5", 22);
`else
        wcnt = 0;
        repeat (100) @(negedge clk);
        check("t5_stuck_busy", 128'(busy), 128'(1'b1));
        check("t5_no_err", 128'(err), 128'(1'b0));
        check("t5_stuck_round", 128'(exp_round), 128'(4'd3));
        n_rst = 1'b0;
        @(negedge clk);
        n_rst           = 1'b1;
        unit_hold_round = 4'd0;
`endif

        // T6: back-to-back runs with a different key.
        launch(K1);
        wait_valid("t6a", 22);
        launch(K6);
        check("t6_kv_drop", 128'(keys_valid), 128'(1'b0));
        check("t6_busy", 128'(busy), 128'(1'b1));
        wait_valid("t6b", 22);
        read_check("t6_rk10", 4'd10, K6_R10);
        read_check("t6_rk0", 4'd0, K6);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
